// File: rtl/cmp_sweep_pkg.sv
// Shared types and widths for the comparator sweep checker.
// Optional two-cycle-per-pair mode is selected with CMP_SWEEP_SETTLE_EN.
package cmp_sweep_pkg;
    localparam int OPW  = 4;
    localparam int IDXW = 8;
    localparam int CNTW = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cmp_ref_model.sv
// Golden unsigned magnitude comparison used as the expected result.
module cmp_ref_model
    import cmp_sweep_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic           e,
    output logic           g,
    output logic           l
);
    assign e = (a == b);
    assign g = (a > b);
    assign l = (a < b);
endmodule

// File: rtl/cmp_sweep_checker.sv
// Exhaustive 4-bit comparator sweep: drives all 256 operand pairs and counts mismatches.
// Define CMP_SWEEP_SETTLE_EN for a drive-then-sample pair (registered comparator under test).
module cmp_sweep_checker
    import cmp_sweep_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [OPW-1:0]  a,
    output logic [OPW-1:0]  b,
    input  logic            e,
    input  logic            g,
    input  logic            l,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] err_count,
    output logic [OPW-1:0]  first_err_a,
    output logic [OPW-1:0]  first_err_b
);
    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] err_q, err_d;
    logic [OPW-1:0]  fa_q, fa_d;
    logic [OPW-1:0]  fb_q, fb_d;
    logic            exp_e, exp_g, exp_l;
    logic            mismatch;
    logic            sample;
`ifdef CMP_SWEEP_SETTLE_EN
    logic            phase_q, phase_d;
`endif

    cmp_ref_model u_ref (
        .a (idx_q[IDXW-1:OPW]),
        .b (idx_q[OPW-1:0]),
        .e (exp_e),
        .g (exp_g),
        .l (exp_l)
    );

    assign mismatch = ({e, g, l} != {exp_e, exp_g, exp_l});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        sample  = 1'b0;
`ifdef CMP_SWEEP_SETTLE_EN
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    err_d   = '0;
                    fa_d    = '0;
                    fb_d    = '0;
`ifdef CMP_SWEEP_SETTLE_EN
                    phase_d = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef CMP_SWEEP_SETTLE_EN
                // First cycle of a pair only drives; the comparator answers a cycle later.
                sample  = phase_q;
                phase_d = ~phase_q;
`else
                sample  = 1'b1;
`endif
                if (sample) begin
                    if (mismatch) begin
                        err_d = err_q + CNTW'(1);
                        // err_q==0 marks the first mismatch of this sweep.
                        if (err_q == '0) begin
                            fa_d = idx_q[IDXW-1:OPW];
                            fb_d = idx_q[OPW-1:0];
                        end
                    end
                    if (idx_q == '1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
`ifdef CMP_SWEEP_SETTLE_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
`ifdef CMP_SWEEP_SETTLE_EN
            phase_q <= phase_d;
`endif
        end
    end

    // Operands come straight from the registered index, so they hold outside RUN.
    assign a           = idx_q[IDXW-1:OPW];
    assign b           = idx_q[OPW-1:0];
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pass        = done && (err_q == '0);
    assign err_count   = err_q;
    assign first_err_a = fa_q;
    assign first_err_b = fb_q;
endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Scoreboard bench: emulated (optionally faulty) comparator, sweep-level reference model.
module tb_cmp_sweep_checker;
`ifdef CMP_SWEEP_SETTLE_EN
    localparam int PER = 2;
`else
    localparam int PER = 1;
`endif
    localparam int SWEEP = 256 * PER;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] a, b;
    logic       e, g, l;
    logic       busy, done, pass;
    logic [8:0] err_count;
    logic [3:0] first_err_a, first_err_b;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;
    logic [2:0] corrupt [256];

    typedef struct {
        int err;
        int fa;
        int fb;
        int pass;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cmp_sweep_checker dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .e           (e),
        .g           (g),
        .l           (l),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .first_err_a (first_err_a),
        .first_err_b (first_err_b)
    );

    // Comparator under test, with selectable faults.
    logic [2:0] ideal, resp;
    always_comb begin
        ideal = {a == b, a > b, a < b};
        resp  = ideal;
        case (mode)
            1: resp = {ideal[2], 1'b0, ideal[0]};
            2: resp = {ideal[2], ideal[0], ideal[1]};
            3: resp = {1'b1, ideal[1], ideal[0]};
            4: resp = 3'b000;
            5: resp = ideal ^ corrupt[{a, b}];
            default: resp = ideal;
        endcase
    end
`ifdef CMP_SWEEP_SETTLE_EN
    always @(posedge clk) {e, g, l} <= resp;
`else
    assign {e, g, l} = resp;
`endif

    function automatic logic [2:0] faulty(int m, int x, int y);
        logic [2:0] r;
        r = {x == y, x > y, x < y};
        case (m)
            1: r[1] = 1'b0;
            2: r = {r[2], r[0], r[1]};
            3: r[2] = 1'b1;
            4: r = 3'b000;
            5: r = r ^ corrupt[x * 16 + y];
            default: ;
        endcase
        return r;
    endfunction

    // Whole-sweep result: walk pairs in A-outer/B-inner order.
    function automatic exp_t model(int m);
        exp_t r;
        logic [2:0] want;
        r = '{err: 0, fa: 0, fb: 0, pass: 1};
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                want = {x == y, x > y, x < y};
                if (faulty(m, x, y) != want) begin
                    if (r.err == 0) begin
                        r.fa = x;
                        r.fb = y;
                    end
                    r.err++;
                end
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_a"}, a, 0);
        check({tag, "_b"}, b, 0);
        check({tag, "_fa"}, first_err_a, 0);
        check({tag, "_fb"}, first_err_b, 0);
    endtask

    // Monitor: checks operand order every RUN cycle, pops and compares on each done rise.
    initial begin
        int   run_len;
        int   pidx;
        bit   prev_done;
        exp_t x;
        run_len   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (run_len < SWEEP) begin
                    pidx = run_len / PER;
                    check("op_a", a, pidx / 16);
                    check("op_b", b, pidx % 16);
                end
                run_len++;
            end else if (!done) begin
                run_len = 0;
            end
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    x = sb_q.pop_front();
                    check("run_cycles", run_len, SWEEP);
                    check("err_count", err_count, x.err);
                    check("first_err_a", first_err_a, x.fa);
                    check("first_err_b", first_err_b, x.fb);
                    check("pass", pass, x.pass);
                    check("busy_at_done", busy, 0);
                    $display("sweep mode=%0d err=%0d first=(%0d,%0d) pass=%0d",
                             mode, err_count, first_err_a, first_err_b, pass);
                end
                run_len = 0;
            end
            prev_done = done;
        end
    end

    task automatic fill_corrupt();
        for (int i = 0; i < 256; i++)
            corrupt[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
    endtask

    task automatic run_sweep(int m, bit pulses);
        int n;
        mode = m;
        if (m == 5) fill_corrupt();
        sb_q.push_back(model(m));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < SWEEP + 50) begin
            start = (pulses && $urandom_range(0, 15) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 0, 1);
            sb_q.delete();
        end
        @(negedge clk);
        check("done_hold", done, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) corrupt[i] = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", busy, 0);
        check("rst_prio_done", done, 0);

        // Directed faults, then back-to-back restarts from DONE.
        for (int m = 0; m <= 4; m++) run_sweep(m, 1'b0);
        for (int k = 0; k < 4; k++) run_sweep(5, 1'b1);
        run_sweep(0, 1'b1);

        // Abandon a sweep at RUN cycle 100, then run a full one.
        mode = 2;
        sb_q.push_back(model(2));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        check_all_zero("abort");
        run_sweep(1, 1'b1);
        run_sweep(5, 1'b0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
